// File: rtl/rpc2_ctrl_reg_axi_slave.sv
// AXI4 slave front-end for the controller register space: single-entry AR/AW holding
// registers, round-robin arbitration, one command at a time toward the register logic.
module rpc2_ctrl_reg_axi_slave #(
  parameter int unsigned C_ID_WIDTH   = 4,
  parameter int unsigned C_ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  // AW channel
  input  logic [C_ID_WIDTH-1:0]   s_awid,
  input  logic [C_ADDR_WIDTH-1:0] s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  // W channel
  input  logic [31:0]             s_wdata,
  input  logic [3:0]              s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  // B channel
  output logic [C_ID_WIDTH-1:0]   s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  // AR channel
  input  logic [C_ID_WIDTH-1:0]   s_arid,
  input  logic [C_ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  // R channel
  output logic [C_ID_WIDTH-1:0]   s_rid,
  output logic [31:0]             s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  // Register logic interface
  output logic                    axi2ip_valid,
  output logic                    axi2ip_rw_n,
  output logic [31:0]             axi2ip_address,
  output logic [1:0]              axi2ip_size,
  output logic [1:0]              axi2ip_burst,
  output logic [7:0]              axi2ip_len,
  input  logic                    ip_ready,
  output logic [31:0]             axi2ip_data,
  output logic [3:0]              axi2ip_strb,
  output logic                    axi2ip_data_valid,
  input  logic                    ip_data_ready,
  input  logic                    ip_wr_done,
  input  logic [1:0]              ip_wr_error,
  input  logic [31:0]             ip_data,
  input  logic                    ip_data_valid,
  input  logic                    ip_data_last,
  input  logic [1:0]              ip_rd_error,
  output logic                    axi2ip_data_ready
);

  typedef enum logic [2:0] {
    StIdle, StRdCmd, StRdData, StWrCmd, StWrData, StWrResp
  } state_e;

  state_e state_q, state_d;

  logic                  ar_full_q, aw_full_q;
  logic [C_ID_WIDTH-1:0] ar_id_q, aw_id_q, cur_id_q;
  logic [31:0]           ar_addr_q, aw_addr_q;
  logic [7:0]            ar_len_q, aw_len_q;
  logic [1:0]            ar_size_q, aw_size_q;
  logic [1:0]            ar_burst_q, aw_burst_q;
  logic [1:0]            bresp_q;
  logic                  rr_last_q;  // 1: last granted command was a write
  logic [31:0]           ar_addr32, aw_addr32;
  logic                  cmd_hs;
  logic                  unused_sig;

  if (C_ADDR_WIDTH >= 32) begin : g_addr_trunc
    assign ar_addr32 = s_araddr[31:0];
    assign aw_addr32 = s_awaddr[31:0];
  end else begin : g_addr_ext
    assign ar_addr32 = {{(32 - C_ADDR_WIDTH){1'b0}}, s_araddr};
    assign aw_addr32 = {{(32 - C_ADDR_WIDTH){1'b0}}, s_awaddr};
  end

  // Beat counting belongs to the register logic, so WLAST and AxSIZE[2] carry no meaning here.
  assign unused_sig = ^{s_wlast, s_arsize[2], s_awsize[2]};

  assign s_arready = ~ar_full_q;
  assign s_awready = ~aw_full_q;
  assign cmd_hs    = axi2ip_valid & ip_ready;
  assign s_rid     = cur_id_q;
  assign s_bid     = cur_id_q;
  assign s_bresp   = bresp_q;
  assign axi2ip_data = s_wdata;
  assign axi2ip_strb = s_wstrb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ar_full_q  <= 1'b0;
      aw_full_q  <= 1'b0;
      ar_id_q    <= '0;
      aw_id_q    <= '0;
      cur_id_q   <= '0;
      ar_addr_q  <= '0;
      aw_addr_q  <= '0;
      ar_len_q   <= '0;
      aw_len_q   <= '0;
      ar_size_q  <= '0;
      aw_size_q  <= '0;
      ar_burst_q <= '0;
      aw_burst_q <= '0;
      bresp_q    <= 2'b00;
      rr_last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (s_arvalid && s_arready) begin
        ar_full_q  <= 1'b1;
        ar_id_q    <= s_arid;
        ar_addr_q  <= ar_addr32;
        ar_len_q   <= s_arlen;
        ar_size_q  <= s_arsize[1:0];
        ar_burst_q <= s_arburst;
      end else if (cmd_hs && axi2ip_rw_n) begin
        ar_full_q <= 1'b0;
      end
      if (s_awvalid && s_awready) begin
        aw_full_q  <= 1'b1;
        aw_id_q    <= s_awid;
        aw_addr_q  <= aw_addr32;
        aw_len_q   <= s_awlen;
        aw_size_q  <= s_awsize[1:0];
        aw_burst_q <= s_awburst;
      end else if (cmd_hs && !axi2ip_rw_n) begin
        aw_full_q <= 1'b0;
      end
      // ID is copied out so the holding register can refill while the response is pending.
      if (cmd_hs) begin
        rr_last_q <= ~axi2ip_rw_n;
        cur_id_q  <= axi2ip_rw_n ? ar_id_q : aw_id_q;
      end
      if (state_q == StWrData && ip_wr_done) begin
        bresp_q <= ip_wr_error;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    axi2ip_valid      = 1'b0;
    axi2ip_rw_n       = (state_q != StWrCmd);
    axi2ip_address    = axi2ip_rw_n ? ar_addr_q  : aw_addr_q;
    axi2ip_size       = axi2ip_rw_n ? ar_size_q  : aw_size_q;
    axi2ip_burst      = axi2ip_rw_n ? ar_burst_q : aw_burst_q;
    axi2ip_len        = axi2ip_rw_n ? ar_len_q   : aw_len_q;
    axi2ip_data_valid = 1'b0;
    axi2ip_data_ready = 1'b0;
    s_wready          = 1'b0;
    s_bvalid          = 1'b0;
    s_rvalid          = 1'b0;
    s_rdata           = '0;
    s_rresp           = 2'b00;
    s_rlast           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ar_full_q && aw_full_q) begin
          state_d = rr_last_q ? StRdCmd : StWrCmd;
        end else if (ar_full_q) begin
          state_d = StRdCmd;
        end else if (aw_full_q) begin
          state_d = StWrCmd;
        end
      end
      StRdCmd: begin
        axi2ip_valid = 1'b1;
        if (ip_ready) state_d = StRdData;
      end
      StRdData: begin
        s_rvalid          = ip_data_valid;
        s_rdata           = ip_data;
        s_rresp           = ip_rd_error;
        s_rlast           = ip_data_last;
        axi2ip_data_ready = s_rready;
        if (ip_data_valid && s_rready && ip_data_last) state_d = StIdle;
      end
      StWrCmd: begin
        axi2ip_valid = 1'b1;
        if (ip_ready) state_d = StWrData;
      end
      StWrData: begin
        s_wready          = ip_data_ready;
        axi2ip_data_valid = s_wvalid;
        if (ip_wr_done) state_d = StWrResp;
      end
      StWrResp: begin
        s_bvalid = 1'b1;
        if (s_bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_rpc2_ctrl_reg_axi_slave.sv
// Randomized bench for rpc2_ctrl_reg_axi_slave: AXI master drivers, a register-logic model
// and scoreboard monitors for commands, W beats, R beats and B responses.
module tb_rpc2_ctrl_reg_axi_slave;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  s_awid = '0, s_arid = '0, s_bid, s_rid;
  logic [31:0] s_awaddr = '0, s_araddr = '0;
  logic [7:0]  s_awlen = '0, s_arlen = '0;
  logic [2:0]  s_awsize = '0, s_arsize = '0;
  logic [1:0]  s_awburst = '0, s_arburst = '0;
  logic        s_awvalid = 1'b0, s_arvalid = 1'b0, s_awready, s_arready;
  logic [31:0] s_wdata = '0, s_rdata;
  logic [3:0]  s_wstrb = '0;
  logic        s_wlast = 1'b0, s_wvalid = 1'b0, s_wready;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready = 1'b0, s_rlast, s_rvalid, s_rready = 1'b0;
  logic        axi2ip_valid, axi2ip_rw_n, ip_ready = 1'b0;
  logic [31:0] axi2ip_address, axi2ip_data, ip_data = '0;
  logic [1:0]  axi2ip_size, axi2ip_burst;
  logic [7:0]  axi2ip_len;
  logic [3:0]  axi2ip_strb;
  logic        axi2ip_data_valid, ip_data_ready = 1'b0, ip_wr_done = 1'b0;
  logic [1:0]  ip_wr_error = '0, ip_rd_error = '0;
  logic        ip_data_valid = 1'b0, ip_data_last = 1'b0, axi2ip_data_ready;

  rpc2_ctrl_reg_axi_slave #(.C_ID_WIDTH(4), .C_ADDR_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .axi2ip_valid(axi2ip_valid), .axi2ip_rw_n(axi2ip_rw_n), .axi2ip_address(axi2ip_address),
    .axi2ip_size(axi2ip_size), .axi2ip_burst(axi2ip_burst), .axi2ip_len(axi2ip_len),
    .ip_ready(ip_ready), .axi2ip_data(axi2ip_data), .axi2ip_strb(axi2ip_strb),
    .axi2ip_data_valid(axi2ip_data_valid), .ip_data_ready(ip_data_ready),
    .ip_wr_done(ip_wr_done), .ip_wr_error(ip_wr_error), .ip_data(ip_data),
    .ip_data_valid(ip_data_valid), .ip_data_last(ip_data_last), .ip_rd_error(ip_rd_error),
    .axi2ip_data_ready(axi2ip_data_ready)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  size;
    logic [1:0]  burst;
  } cmd_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } wbeat_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bresp_t;

  cmd_t   exp_rd[$], exp_wr[$];
  rbeat_t exp_r[$];
  wbeat_t w_tx[$], exp_w[$];
  bresp_t exp_b[$];
  bit     cmd_log[$];

  int tests = 0;
  int errs  = 0;
  bit ip_manual = 1'b0, ip_busy = 1'b0, r_stall = 1'b0, b_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response codes the register-logic model returns for a given access
  function automatic logic [1:0] rd_err(input logic [31:0] a);
    return (a >= 32'h100) ? 2'b11 : 2'b00;
  endfunction
  function automatic logic [1:0] wr_err(input logic [31:0] a, input logic [7:0] len);
    if (a >= 32'h100) return 2'b11;
    return (len == 8'd3) ? 2'b10 : 2'b00;
  endfunction

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    cmd_t c;
    bit hs = 1'b0;
    c.id = id; c.addr = addr; c.len = len; c.size = 2'd2; c.burst = 2'b01;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = 3'd2; s_arburst = 2'b01;
    s_arvalid = 1'b1;
    for (int n = 0; n < 500 && !hs; n++) begin
      @(negedge clk);
      hs = s_arready;
      tick();
    end
    s_arvalid = 1'b0;
    check("ar_accepted", hs, 1);
    if (hs) exp_rd.push_back(c);
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [3:0] strb);
    cmd_t   c;
    wbeat_t w;
    bit hs = 1'b0;
    c.id = id; c.addr = addr; c.len = len; c.size = 2'd2; c.burst = 2'b01;
    for (int b = 0; b <= int'(len); b++) begin
      w.data = $urandom;
      w.strb = strb;
      w_tx.push_back(w);
      exp_w.push_back(w);
    end
    s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = 3'd2; s_awburst = 2'b01;
    s_awvalid = 1'b1;
    for (int n = 0; n < 500 && !hs; n++) begin
      @(negedge clk);
      hs = s_awready;
      tick();
    end
    s_awvalid = 1'b0;
    check("aw_accepted", hs, 1);
    if (hs) exp_wr.push_back(c);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      tick();
      done = (exp_rd.size() == 0) && (exp_wr.size() == 0) && (exp_r.size() == 0) &&
             (exp_b.size() == 0) && (w_tx.size() == 0) && !ip_busy && !s_rvalid &&
             !s_bvalid && !axi2ip_valid;
    end
    check("idle_reached", done, 1);
    repeat (2) tick();
  endtask

  // W master: presents queued beats; W may be queued before its AW
  initial begin
    bit hs;
    forever begin
      @(negedge clk);
      hs = s_wvalid && s_wready;
      tick();
      if (hs && w_tx.size() > 0) void'(w_tx.pop_front());
      if (w_tx.size() > 0) begin
        s_wvalid = 1'b1;
        s_wdata  = w_tx[0].data;
        s_wstrb  = w_tx[0].strb;
        s_wlast  = (w_tx.size() == 1);
      end else begin
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      tick();
      s_rready = !r_stall && ($urandom_range(0, 3) != 0);
      s_bready = !b_stall && ($urandom_range(0, 3) != 0);
    end
  end

  // Register-logic model: accepts commands, checks them in per-direction order, serves beats
  initial begin
    cmd_t   got, e;
    rbeat_t rb;
    wbeat_t ew;
    bit     hs;
    int     beats;
    forever begin
      @(negedge clk);
      if (reset_n && axi2ip_valid && !ip_manual) begin
        tick();
        repeat ($urandom_range(0, 2)) tick();
        ip_ready = 1'b1;
        @(negedge clk);
        check("cmd_valid_held", axi2ip_valid, 1);
        got.id = '0; got.addr = axi2ip_address; got.len = axi2ip_len;
        got.size = axi2ip_size; got.burst = axi2ip_burst;
        hs = axi2ip_rw_n;
        ip_busy = 1'b1;
        tick();
        ip_ready = 1'b0;
        cmd_log.push_back(hs);
        if ((hs && exp_rd.size() == 0) || (!hs && exp_wr.size() == 0)) begin
          tests++; errs++;
          $display("FAIL cmd_unexpected: got rw_n=%0d addr %0h, expected no command", hs,
                   got.addr);
        end else if (hs) begin
          e = exp_rd.pop_front();
          check("rd_cmd_fields", {got.addr, got.len, got.size, got.burst},
                {e.addr, e.len, e.size, e.burst});
          for (int b = 0; b <= int'(e.len); b++) begin
            if ($urandom_range(0, 2) == 0) tick();
            ip_data       = $urandom;
            ip_data_last  = (b == int'(e.len));
            ip_rd_error   = rd_err(e.addr);
            ip_data_valid = 1'b1;
            rb.id = e.id; rb.data = ip_data; rb.resp = rd_err(e.addr); rb.last = ip_data_last;
            exp_r.push_back(rb);
            hs = 1'b0;
            for (int n = 0; n < 300 && !hs; n++) begin
              @(negedge clk);
              hs = axi2ip_data_ready;
              tick();
            end
            check("r_beat_taken", hs, 1);
            ip_data_valid = 1'b0;
            ip_data_last  = 1'b0;
          end
        end else begin
          e = exp_wr.pop_front();
          check("wr_cmd_fields", {got.addr, got.len, got.size, got.burst},
                {e.addr, e.len, e.size, e.burst});
          ip_wr_error = wr_err(e.addr, e.len);
          beats = 0;
          for (int n = 0; n < 300 && beats <= int'(e.len); n++) begin
            ip_data_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (axi2ip_data_valid && ip_data_ready) begin
              if (exp_w.size() == 0) begin
                tests++; errs++;
                $display("FAIL w_unexpected: got data %0h, expected no beat", axi2ip_data);
              end else begin
                ew = exp_w.pop_front();
                check("w_data", axi2ip_data, ew.data);
                check("w_strb", axi2ip_strb, ew.strb);
              end
              beats++;
            end
            tick();
          end
          check("w_beat_count", beats, int'(e.len) + 1);
          ip_data_ready = 1'b0;
          ip_wr_done    = 1'b1;
          exp_b.push_back('{id: e.id, resp: wr_err(e.addr, e.len)});
          tick();
          ip_wr_done = 1'b0;
        end
        ip_busy = 1'b0;
      end
    end
  end

  // R monitor
  initial begin
    rbeat_t e;
    forever begin
      @(negedge clk);
      if (reset_n && s_rvalid && s_rready) begin
        if (exp_r.size() == 0) begin
          tests++; errs++;
          $display("FAIL r_unexpected: got rdata %0h, expected no beat", s_rdata);
        end else begin
          e = exp_r.pop_front();
          check("r_id", s_rid, e.id);
          check("r_data", s_rdata, e.data);
          check("r_resp", s_rresp, e.resp);
          check("r_last", s_rlast, e.last);
        end
      end
    end
  end

  // B monitor: BVALID before the write completed has no matching expectation
  initial begin
    bresp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && s_bvalid) begin
        if (exp_b.size() == 0) begin
          tests++; errs++;
          $display("FAIL b_early: got bvalid=1, expected 0 (no write done)");
        end else if (s_bready) begin
          e = exp_b.pop_front();
          check("b_id", s_bid, e.id);
          check("b_resp", s_bresp, e.resp);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_log[7];
    bit seen;
    exp_log = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    repeat (3) tick();
    @(negedge clk);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_cmd_valid", axi2ip_valid, 0);
    check("rst_wready", s_wready, 0);
    check("rst_bresp", s_bresp, 0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_arready", s_arready, 1);
    check("rel_awready", s_awready, 1);
    tick();

    // Ties: read first after reset, read again after a write, write after a lone read
    fork
      send_ar(4'h1, 32'h08, 8'd0);
      send_aw(4'h2, 32'h04, 8'd0, 4'h3);
    join
    wait_idle();
    fork
      send_ar(4'h3, 32'h08, 8'd1);
      send_aw(4'h4, 32'h10, 8'd1, 4'hf);
    join
    wait_idle();
    send_ar(4'h5, 32'h100, 8'd0);
    wait_idle();
    fork
      send_ar(4'h6, 32'h0c, 8'd0);
      send_aw(4'h7, 32'h04, 8'd3, 4'hf);
    join
    wait_idle();
    check("log_len", cmd_log.size(), 7);
    for (int i = 0; i < 7 && i < cmd_log.size(); i++) check("arb_order", cmd_log[i], exp_log[i]);

    // R backpressure with a second read waiting in the holding register
    r_stall = 1'b1;
    tick();
    send_ar(4'h8, 32'h20, 8'd0);
    send_ar(4'h9, 32'h24, 8'd0);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = s_rvalid;
    end
    check("r_stall_seen", seen, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("r_stall_valid", s_rvalid, 1);
      if (exp_r.size() > 0) check("r_stall_data", s_rdata, exp_r[0].data);
      check("r_stall_nocmd", axi2ip_valid, 0);
    end
    tick();
    r_stall = 1'b0;
    wait_idle();

    // B backpressure with a read waiting
    b_stall = 1'b1;
    tick();
    send_aw(4'ha, 32'h0c, 8'd0, 4'h5);
    send_ar(4'hb, 32'h28, 8'd0);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = s_bvalid;
    end
    check("b_stall_seen", seen, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b_stall_valid", s_bvalid, 1);
      if (exp_b.size() > 0) check("b_stall_id", s_bid, exp_b[0].id);
      if (exp_b.size() > 0) check("b_stall_resp", s_bresp, exp_b[0].resp);
      check("b_stall_nocmd", axi2ip_valid, 0);
    end
    tick();
    b_stall = 1'b0;
    wait_idle();

    // Random concurrent reads and writes
    fork
      for (int i = 0; i < 15; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        send_ar(4'($urandom), {23'd0, 7'($urandom), 2'b00}, 8'($urandom_range(0, 3)));
      end
      for (int i = 0; i < 15; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        send_aw(4'($urandom), {23'd0, 7'($urandom), 2'b00}, 8'($urandom_range(0, 3)),
                4'($urandom));
      end
    join
    wait_idle();

    // Reset in the middle of a write burst
    ip_manual = 1'b1;
    send_aw(4'hc, 32'h40, 8'd3, 4'hf);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = axi2ip_valid;
    end
    check("mid_cmd_seen", seen, 1);
    tick();
    ip_ready = 1'b1;
    tick();
    ip_ready = 1'b0;
    ip_data_ready = 1'b1;
    @(negedge clk);
    check("mid_wready", s_wready, 1);
    tick();
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_wready", s_wready, 0);
    check("mid_rst_wdvalid", axi2ip_data_valid, 0);
    check("mid_rst_cmd", axi2ip_valid, 0);
    check("mid_rst_bvalid", s_bvalid, 0);
    check("mid_rst_rvalid", s_rvalid, 0);
    ip_data_ready = 1'b0;
    w_tx.delete();
    exp_w.delete();
    exp_wr.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_awready", s_awready, 1);
    check("post_arready", s_arready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_no_bvalid", s_bvalid, 0);
      check("post_no_cmd", axi2ip_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
